// File: rtl/bram_bist_pkg.sv
// Shared encodings for the BRAM exerciser: FSM states, run modes and the
// legal range of the BRAM read latency.
package bram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] MODE_WR_RD = 2'd0;
  localparam logic [1:0] MODE_WR    = 2'd1;
  localparam logic [1:0] MODE_RD    = 2'd2;
  localparam logic [1:0] MODE_RSV   = 2'd3;

  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 3;

  function automatic bit rd_latency_ok(input int lat);
    return (lat >= RD_LATENCY_MIN) && (lat <= RD_LATENCY_MAX);
  endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// Delay line carrying {issue, expected word} so it lines up with the BRAM
// read data DEPTH cycles after the read was issued.
module bram_rd_pipe #(
  parameter int W     = 16,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [W:0] line [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) line[i] <= '0;
    end else begin
      line[0] <= {in_valid, in_data};
      for (int i = 1; i < DEPTH; i++) line[i] <= line[i-1];
    end
  end

  assign {out_valid, out_data} = line[DEPTH-1];

endmodule

// File: rtl/bram_bist_ctrl.sv
// BRAM exerciser: writes an incrementing (optionally inverted) pattern over a
// wrapping address window, reads it back and counts mismatching words.
module bram_bist_ctrl
  import bram_bist_pkg::*;
#(
  parameter int DWIDTH     = 16,
  parameter int AWIDTH     = 12,
  parameter int MEM_SIZE   = 3840,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_run,
  input  logic [1:0]        i_mode,
  input  logic [AWIDTH-1:0] i_start_addr,
  input  logic [AWIDTH:0]   i_num_cnt,
  input  logic [DWIDTH-1:0] i_seed,
  input  logic              i_pat_inv,
  output logic              o_idle,
  output logic              o_write,
  output logic              o_read,
  output logic              o_done,
  output logic [AWIDTH:0]   o_err_cnt,
  output logic              o_pass,
  output logic [AWIDTH-1:0] addr0,
  output logic              ce0,
  output logic              we0,
  output logic [DWIDTH-1:0] d0,
  input  logic [DWIDTH-1:0] q0,
  output logic              o_valid,
  output logic [DWIDTH-1:0] o_mem_data
);

  if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_latency
    $error("bram_bist_ctrl: RD_LATENCY must be 1..3");
  end

  localparam logic [AWIDTH:0] MEM_SIZE_W = (AWIDTH+1)'(MEM_SIZE);

  state_t              state;
  logic [1:0]          mode_q;
  logic [AWIDTH-1:0]   start_q;
  logic [DWIDTH-1:0]   seed_q;
  logic                inv_q;
  logic [AWIDTH:0]     cnt_q;
  logic [AWIDTH:0]     left_q;
  logic [DWIDTH-1:0]   word_q;
  logic [1:0]          drain_q;

  logic [1:0]          mode_n;
  logic [AWIDTH:0]     cnt_eff;
  logic [AWIDTH:0]     start_ext;
  logic [AWIDTH-1:0]   start_w;
  logic [DWIDTH-1:0]   word_inc;
  logic [DWIDTH-1:0]   mask_q;
  logic                pipe_valid;
  logic [DWIDTH-1:0]   pipe_exp;

  // Wrap by a single conditional subtract; offsets only ever step by one.
  function automatic logic [AWIDTH-1:0] next_addr(input logic [AWIDTH-1:0] a);
    logic [AWIDTH:0] s;
    s = {1'b0, a} + 1'b1;
    if (s >= MEM_SIZE_W) s = s - MEM_SIZE_W;
    return s[AWIDTH-1:0];
  endfunction

  always_comb begin
    mode_n    = (i_mode == MODE_RSV) ? MODE_WR_RD : i_mode;
    cnt_eff   = (i_num_cnt > MEM_SIZE_W) ? MEM_SIZE_W : i_num_cnt;
    start_ext = {1'b0, i_start_addr};
    if (start_ext >= MEM_SIZE_W) start_ext = start_ext - MEM_SIZE_W;
    start_w   = start_ext[AWIDTH-1:0];
    word_inc  = word_q + 1'b1;
    mask_q    = {DWIDTH{inv_q}};
  end

  assign o_idle  = (state == ST_IDLE);
  assign o_write = (state == ST_WRITE);
  assign o_read  = (state == ST_READ);
  assign o_done  = (state == ST_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      mode_q  <= MODE_WR_RD;
      start_q <= '0;
      seed_q  <= '0;
      inv_q   <= 1'b0;
      cnt_q   <= '0;
      left_q  <= '0;
      word_q  <= '0;
      drain_q <= '0;
      o_pass  <= 1'b0;
      addr0   <= '0;
      ce0     <= 1'b0;
      we0     <= 1'b0;
      d0      <= '0;
    end else begin
      case (state)
        ST_IDLE: if (i_run) begin
          mode_q  <= mode_n;
          start_q <= start_w;
          seed_q  <= i_seed;
          inv_q   <= i_pat_inv;
          cnt_q   <= cnt_eff;
          o_pass  <= 1'b0;
          left_q  <= cnt_eff - 1'b1;
          word_q  <= i_seed;
          addr0   <= start_w;
          if (cnt_eff == '0) begin
            state <= ST_DONE;
          end else if (mode_n == MODE_RD) begin
            state <= ST_READ;
            ce0   <= 1'b1;
            we0   <= 1'b0;
          end else begin
            state <= ST_WRITE;
            ce0   <= 1'b1;
            we0   <= 1'b1;
            d0    <= i_seed ^ {DWIDTH{i_pat_inv}};
          end
        end
        ST_WRITE: if (left_q == '0) begin
          if (mode_q == MODE_WR) begin
            state <= ST_DONE;
            ce0   <= 1'b0;
            we0   <= 1'b0;
          end else begin
            state  <= ST_READ;
            we0    <= 1'b0;
            addr0  <= start_q;
            word_q <= seed_q;
            left_q <= cnt_q - 1'b1;
          end
        end else begin
          addr0  <= next_addr(addr0);
          word_q <= word_inc;
          d0     <= word_inc ^ mask_q;
          left_q <= left_q - 1'b1;
        end
        ST_READ: if (left_q == '0) begin
          state   <= ST_DRAIN;
          ce0     <= 1'b0;
          drain_q <= '0;
        end else begin
          addr0  <= next_addr(addr0);
          word_q <= word_inc;
          left_q <= left_q - 1'b1;
        end
        // Hold RD_LATENCY+1 cycles so the last compare lands before DONE.
        ST_DRAIN: if (drain_q == 2'(RD_LATENCY)) state <= ST_DONE;
                  else drain_q <= drain_q + 1'b1;
        ST_DONE: begin
          o_pass <= (mode_q != MODE_WR) && (cnt_q != '0) && (o_err_cnt == '0);
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  bram_rd_pipe #(
    .W     (DWIDTH),
    .DEPTH (RD_LATENCY)
  ) u_rd_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (ce0 & ~we0),
    .in_data   (word_q ^ mask_q),
    .out_valid (pipe_valid),
    .out_data  (pipe_exp)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_valid    <= 1'b0;
      o_mem_data <= '0;
      o_err_cnt  <= '0;
    end else begin
      o_valid <= pipe_valid;
      if (pipe_valid) o_mem_data <= q0;
      if (o_idle && i_run) o_err_cnt <= '0;
      else if (pipe_valid && (q0 != pipe_exp) && (o_err_cnt != '1))
        o_err_cnt <= o_err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bram_bist_ctrl.sv
// Directed bench for bram_bist_ctrl with a behavioural single-port BRAM model.
module tb_bram_bist_ctrl;

  localparam int DW  = 16;
  localparam int AW  = 12;
  localparam int MSZ = 3840;
  parameter int RD_LAT = 1;

  logic          clk;
  logic          reset_n;
  logic          i_run;
  logic [1:0]    i_mode;
  logic [AW-1:0] i_start_addr;
  logic [AW:0]   i_num_cnt;
  logic [DW-1:0] i_seed;
  logic          i_pat_inv;
  logic          o_idle, o_write, o_read, o_done;
  logic [AW:0]   o_err_cnt;
  logic          o_pass;
  logic [AW-1:0] addr0;
  logic          ce0, we0;
  logic [DW-1:0] d0, q0;
  logic          o_valid;
  logic [DW-1:0] o_mem_data;

  bram_bist_ctrl #(
    .DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(MSZ), .RD_LATENCY(RD_LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_mode(i_mode),
    .i_start_addr(i_start_addr), .i_num_cnt(i_num_cnt), .i_seed(i_seed),
    .i_pat_inv(i_pat_inv), .o_idle(o_idle), .o_write(o_write), .o_read(o_read),
    .o_done(o_done), .o_err_cnt(o_err_cnt), .o_pass(o_pass), .addr0(addr0),
    .ce0(ce0), .we0(we0), .d0(d0), .q0(q0), .o_valid(o_valid),
    .o_mem_data(o_mem_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model with optional single-bit corruption of address 5 on read
  bit [DW-1:0] mem [0:MSZ-1];
  bit [DW-1:0] rp  [0:2];
  bit          corrupt;

  always @(posedge clk) begin
    if (ce0 && we0) mem[addr0] <= d0;
    if (ce0 && !we0) rp[0] <= mem[addr0] ^ ((corrupt && addr0 == 5) ? 16'h0001 : 16'h0000);
    rp[1] <= rp[0];
    rp[2] <= rp[1];
  end
  assign q0 = rp[RD_LAT-1];

  // monitor, sampled on the falling edge
  logic [AW-1:0] wr_addr_q[$], rd_addr_q[$];
  logic [DW-1:0] wr_data_q[$], val_q[$];
  logic [DW-1:0] exp_q[$];
  int cyc, first_rd, first_val, last_val, done_cyc, run_cyc, done_n, ce_n;
  int n_vec, n_miss;

  initial cyc = 0;
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (ce0) ce_n++;
    if (ce0 && we0) begin wr_addr_q.push_back(addr0); wr_data_q.push_back(d0); end
    if (ce0 && !we0) begin
      rd_addr_q.push_back(addr0);
      if (first_rd < 0) first_rd = cyc;
    end
    if (o_valid) begin
      val_q.push_back(o_mem_data);
      if (first_val < 0) first_val = cyc;
      last_val = cyc;
    end
    if (o_done) begin done_n++; done_cyc = cyc; end
    if (i_run && o_idle) run_cyc = cyc;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    wr_addr_q.delete(); rd_addr_q.delete(); wr_data_q.delete(); val_q.delete();
    exp_q.delete();
    first_rd = -1; first_val = -1; last_val = -1; done_cyc = -1; run_cyc = -1;
    done_n = 0; ce_n = 0;
  endtask

  task automatic start_run(input logic [1:0] mode, input int start, input int num,
                           input int seed, input logic inv);
    @(posedge clk); #1;
    i_mode = mode; i_start_addr = AW'(start); i_num_cnt = (AW+1)'(num);
    i_seed = DW'(seed); i_pat_inv = inv; i_run = 1'b1;
    @(posedge clk); #1;
    i_run = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (done_n == 0 && i < budget) begin @(posedge clk); i++; end
    if (done_n == 0) check("timeout", 0, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int b_addr [4];
    n_vec = 0; n_miss = 0; corrupt = 1'b0;
    clear_logs();
    reset_n = 1'b0; i_run = 1'b0; i_mode = '0; i_start_addr = '0;
    i_num_cnt = '0; i_seed = '0; i_pat_inv = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rst_idle", int'(o_idle), 1);
    check("rst_done", int'(o_done), 0);
    check("rst_ce0", int'(ce0), 0);
    check("rst_we0", int'(we0), 0);
    check("rst_addr0", int'(addr0), 0);
    check("rst_d0", int'(d0), 0);
    check("rst_err", int'(o_err_cnt), 0);
    check("rst_pass", int'(o_pass), 0);
    check("rst_valid", int'(o_valid), 0);
    check("rst_mdata", int'(o_mem_data), 0);
    @(negedge clk) reset_n = 1'b1;

    // A: write+read 16 words from 0, seed 0
    clear_logs();
    for (int k = 0; k < 16; k++) exp_q.push_back(DW'(k));
    start_run(2'd0, 0, 16, 0, 1'b0);
    wait_done(200);
    check("a_wr_n", wr_addr_q.size(), 16);
    check("a_rd_n", rd_addr_q.size(), 16);
    check("a_val_n", val_q.size(), 16);
    for (int k = 0; k < 16 && k < val_q.size() && k < wr_data_q.size(); k++) begin
      check("a_wdata", int'(wr_data_q[k]), k);
      check("a_rdata", int'(val_q[k]), int'(exp_q.pop_front()));
    end
    check("a_err", int'(o_err_cnt), 0);
    check("a_pass", int'(o_pass), 1);
    check("a_done_n", done_n, 1);
    check("a_val_lat", first_val - first_rd, RD_LAT + 1);
    check("a_done_gap", done_cyc - last_val, 1);

    // B: reserved mode behaves as write+read; window wraps at MEM_SIZE
    clear_logs();
    b_addr = '{3838, 3839, 0, 1};
    start_run(2'd3, 3838, 4, 16'h0100, 1'b0);
    wait_done(200);
    check("b_wr_n", wr_addr_q.size(), 4);
    check("b_rd_n", rd_addr_q.size(), 4);
    for (int k = 0; k < 4 && k < wr_addr_q.size() && k < rd_addr_q.size(); k++) begin
      check("b_wr_addr", int'(wr_addr_q[k]), b_addr[k]);
      check("b_rd_addr", int'(rd_addr_q[k]), b_addr[k]);
    end
    check("b_err", int'(o_err_cnt), 0);
    check("b_pass", int'(o_pass), 1);

    // D: empty window goes straight to done without touching the BRAM
    clear_logs();
    start_run(2'd0, 0, 0, 0, 1'b0);
    wait_done(50);
    check("d_ce_n", ce_n, 0);
    check("d_done_lat", done_cyc - run_cyc, 1);
    check("d_done_n", done_n, 1);
    check("d_pass", int'(o_pass), 0);
    check("d_err", int'(o_err_cnt), 0);

    // C: model corrupts address 5 on read -> exactly one mismatch
    clear_logs();
    corrupt = 1'b1;
    start_run(2'd0, 0, 8, 16'h0055, 1'b1);
    wait_done(200);
    corrupt = 1'b0;
    check("c_val_n", val_q.size(), 8);
    check("c_err", int'(o_err_cnt), 1);
    check("c_pass", int'(o_pass), 0);

    // E: oversized count clamps to MEM_SIZE; write-only never passes
    clear_logs();
    start_run(2'd1, 0, 5000, 16'h1234, 1'b0);
    wait_done(5000);
    check("e_wr_n", wr_addr_q.size(), 3840);
    check("e_rd_n", rd_addr_q.size(), 0);
    if (wr_addr_q.size() == 3840) begin
      check("e_first_addr", int'(wr_addr_q[0]), 0);
      check("e_last_addr", int'(wr_addr_q[3839]), 3839);
      check("e_last_data", int'(wr_data_q[3839]), 16'h2133);
    end
    check("e_pass", int'(o_pass), 0);
    check("e_err", int'(o_err_cnt), 0);

    // F: read-only over data left by E (mem[a] = 0x1234 + a)
    clear_logs();
    start_run(2'd2, 100, 10, 16'h1298, 1'b0);
    wait_done(200);
    check("f_wr_n", wr_addr_q.size(), 0);
    check("f_rd_n", rd_addr_q.size(), 10);
    check("f_err", int'(o_err_cnt), 0);
    check("f_pass", int'(o_pass), 1);
    check("f_val_lat", first_val - first_rd, RD_LAT + 1);

    // G: reset in the middle of READ, then read-only inverted run
    clear_logs();
    start_run(2'd0, 2000, 64, 7, 1'b0);
    for (int i = 0; i < 300 && !o_read; i++) @(posedge clk);
    check("g_reached_read", int'(o_read), 1);
    repeat (5) @(posedge clk);
    @(negedge clk) reset_n = 1'b0;
    #2;
    check("g_rst_idle", int'(o_idle), 1);
    check("g_rst_ce0", int'(ce0), 0);
    check("g_rst_we0", int'(we0), 0);
    check("g_rst_addr0", int'(addr0), 0);
    check("g_rst_d0", int'(d0), 0);
    check("g_rst_valid", int'(o_valid), 0);
    check("g_rst_mdata", int'(o_mem_data), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    check("g_no_done", done_n, 0);
    clear_logs();
    start_run(2'd2, 1000, 8, 0, 1'b1);
    wait_done(200);
    check("g_val_n", val_q.size(), 8);
    if (val_q.size() > 0) check("g_first_data", int'(val_q[0]), 16'h161C);
    check("g_err", int'(o_err_cnt), 8);
    check("g_pass", int'(o_pass), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
